// File: rtl/div_unit_radix2_pkg.sv
// Shared definitions for the radix-2 divider: state encodings and widths.
package div_unit_radix2_pkg;
  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring division step on a WIDTH+1-bit partial remainder.
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] d,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] d_ext;

  // The shift may wrap modulo 2^(WIDTH+1); the add/sub result always fits, so the wrap cancels.
  assign shifted  = {rem[WIDTH-1:0], bit_in};
  assign d_ext    = {1'b0, d};
  assign rem_next = rem[WIDTH] ? (shifted + d_ext) : (shifted - d_ext);
  assign qbit     = ~rem_next[WIDTH];
endmodule

// File: rtl/div_unit_radix2.sv
// Sequential radix-2 non-restoring divider (DIV/MOD/DIVU/MODU), one quotient bit per cycle,
// with an enable/ready/complete handshake toward the ALU.
module div_unit_radix2
  import div_unit_radix2_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             ready,
  output logic             complete
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] op1_l;
  logic             s1, s2;
  logic             div_zero, ovf;

  logic             neg1, neg2;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quo_res, rem_res;

  assign neg1 = sign_en & op1[WIDTH-1];
  assign neg2 = sign_en & op2[WIDTH-1];

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .d        (d_reg),
    .bit_in   (q_reg[WIDTH-1]),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  // Final correction and sign application; the low WIDTH bits suffice since the
  // corrected remainder lies in [0, D).
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rem_mag = rem_reg[WIDTH] ? (rem_reg[WIDTH-1:0] + d_reg) : rem_reg[WIDTH-1:0];
    quo_res = (s1 ^ s2) ? -q_reg : q_reg;
    rem_res = s1 ? -rem_mag : rem_mag;
    if (div_zero) begin
      quo_res = '1;
      rem_res = op1_l;
    end else if (ovf) begin
      quo_res = {1'b1, {(WIDTH-1){1'b0}}};
      rem_res = '0;
    end
  end

  // NOTE: reset is synchronous here -- it is sampled only on the rising clock edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= DIV_IDLE;
      ready    <= 1'b1;
      complete <= 1'b0;
      quo_o    <= '0;
      rem_o    <= '0;
      cnt      <= '0;
      rem_reg  <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      op1_l    <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      complete <= 1'b0;
      unique case (state)
        DIV_IDLE, DIV_DONE: begin
          if (enable) begin
            s1       <= neg1;
            s2       <= neg2;
            op1_l    <= op1;
            q_reg    <= neg1 ? -op1 : op1;
            d_reg    <= neg2 ? -op2 : op2;
            rem_reg  <= '0;
            cnt      <= CNT_W'(WIDTH - 1);
            div_zero <= (op2 == '0);
            ovf      <= sign_en && (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1);
            state    <= DIV_ITER;
            ready    <= 1'b0;
          end else begin
            state <= DIV_IDLE;
            ready <= 1'b1;
          end
        end
        DIV_ITER: begin
          rem_reg <= step_rem;
          q_reg   <= {q_reg[WIDTH-2:0], step_q};
          cnt     <= cnt - 1'b1;
          if (cnt == '0) state <= DIV_FIX;
        end
        DIV_FIX: begin
          quo_o    <= quo_res;
          rem_o    <= rem_res;
          complete <= 1'b1;
          ready    <= 1'b1;
          state    <= DIV_DONE;
        end
        default: begin
          state <= DIV_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit_radix2.sv
// Self-checking bench for div_unit_radix2: vector table, corner-case sequences and a
// random regression, all scored through an expected-result queue.
module tb_div_unit_radix2;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         enable = 1'b0;
  logic         sign_en = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [W-1:0] quo_o, rem_o;
  logic         ready, complete;

  div_unit_radix2 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .sign_en  (sign_en),
    .op1      (op1),
    .op2      (op2),
    .quo_o    (quo_o),
    .rem_o    (rem_o),
    .ready    (ready),
    .complete (complete)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           acc;
  } exp_t;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard side: compare each complete pulse against the oldest expectation.
  logic prev_c = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (prev_c) check("complete_width", W'(complete), '0);
    if (complete) begin
      if (sb.size() == 0) fail_now("spurious_complete");
      else begin
        e = sb.pop_front();
        check("quo_o", quo_o, e.q);
        check("rem_o", rem_o, e.r);
        check("latency", W'(cyc - e.acc), W'(LAT));
      end
    end
    prev_c = complete;
  end

  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] eq, input logic [W-1:0] er);
    int t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) fail_now("ready_timeout");
    sign_en = s;
    op1     = a;
    op2     = b;
    enable  = 1'b1;
    @(posedge clk);
    if (push) sb.push_back('{q: eq, r: er, acc: cyc});
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic drain(input int extra);
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("result_timeout");
      sb.delete();
    end
    repeat (extra) @(negedge clk);
  endtask

  vec_t         tbl[13];
  logic [W-1:0] rq, rr, ra, rb;
  logic         rs;
  int           busy_hi;
  int           t;

  initial begin
    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};
    tbl[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tbl[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    tbl[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    tbl[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    tbl[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    tbl[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    tbl[10] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};
    tbl[11] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1};
    tbl[12] = '{1'b1, 32'd0,          32'd3,          32'd0,          32'd0};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", W'(ready), W'(1));
    check("reset_complete", W'(complete), '0);
    check("reset_quo", quo_o, '0);
    check("reset_rem", rem_o, '0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic unsigned op with busy window: ready low for cycles 1..33, complete at 34.
    start(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    busy_hi = 0;
    for (int k = 1; k <= LAT - 1; k++) begin
      if (ready) busy_hi++;
      @(negedge clk);
    end
    check("busy_ready_high_cycles", W'(busy_hi), '0);
    check("ready_in_done", W'(ready), W'(1));
    drain(2);

    foreach (tbl[i]) begin
      start(tbl[i].s, tbl[i].a, tbl[i].b, 1'b1, tbl[i].q, tbl[i].r);
      drain(2);
    end

    // Enable pulse and operand change while busy must not disturb the running op.
    start(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    repeat (9) @(negedge clk);
    op1 = 32'd9;
    op2 = 32'd3;
    sign_en = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (9) @(negedge clk);
    op1 = 32'hDEAD_BEEF;
    drain(40);

    // Reset in the middle of ITER: outputs clear and no completion follows.
    start(1'b0, 32'd100, 32'd7, 1'b0, '0, '0);
    repeat (11) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_ready", W'(ready), W'(1));
    check("midreset_quo", quo_o, '0);
    check("midreset_rem", rem_o, '0);
    check("midreset_complete", W'(complete), '0);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    start(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0);
    drain(2);

    // Back-to-back: enable held through the busy period, accepted on the DONE edge.
    start(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    sign_en = 1'b0;
    op1 = 32'd81;
    op2 = 32'd9;
    enable = 1'b1;
    t = 0;
    while (!complete && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!complete) fail_now("b2b_complete_timeout");
    @(posedge clk);
    sb.push_back('{q: 32'd9, r: 32'd0, acc: cyc});
    @(negedge clk);
    enable = 1'b0;
    drain(2);

    for (int i = 0; i < 40; i++) begin
      rs = 1'(($urandom_range(0, 1)));
      ra = $urandom;
      if (i % 8 == 0)      rb = '0;
      else if (i % 3 == 0) rb = rs ? -W'($urandom_range(1, 20)) : W'($urandom_range(1, 20));
      else                 rb = $urandom >> $urandom_range(0, 31);
      if (i == 5) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      ref_div(rs, ra, rb, rq, rr);
      start(rs, ra, rb, 1'b1, rq, rr);
      drain(0);
    end
    drain(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
